// File: rtl/rv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, opcode constants,
// the canonical NOP and the fetch state encoding.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = {25'd0, OP_IMM};

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        FULL,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle around the fetch stage: instruction-memory request/response,
// redirect inputs from execute and the valid/ready link to decode.
// master = fetch stage, slave = memory/execute/decode environment.
interface fetch_unit_if
    import rv_pkg::*;
#(
    parameter int XLEN = rv_pkg::XLEN
);

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    logic            branch;
    logic            jump;
    logic            br_cond;
    logic [XLEN-1:0] target_addr;

    logic            id_ready;
    logic            if_valid;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic [6:0]      if_opcode;

    modport master (
        output imem_req, imem_addr,
        input  imem_rvalid, imem_rdata,
        input  branch, jump, br_cond, target_addr,
        input  id_ready,
        output if_valid, if_instr, if_pc, if_opcode
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rvalid, imem_rdata,
        output branch, jump, br_cond, target_addr,
        output id_ready,
        input  if_valid, if_instr, if_pc, if_opcode
    );

endinterface

// File: rtl/pc_reg.sv
// Program counter: holds the fetch address and selects between the
// sequential successor (PC+4, wrapping) and a word-aligned redirect target.
module pc_reg
    import rv_pkg::*;
#(
    parameter int              XLEN     = rv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_target,
    input  logic            advance,
    input  logic [XLEN-1:0] target_addr,
    output logic [XLEN-1:0] pc_q
);

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] pc_d;
    logic            pc_en;

    // Redirect outranks sequential advance; the target is forced word-aligned.
    always_comb begin
        pc_d  = pc_q + PC_STEP;
        pc_en = load_target | advance;
        if (load_target) begin
            pc_d = target_addr & ALIGN_MASK;
        end
    end

    // PC register, loaded only when the fetch FSM asks for it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (pc_en) begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding memory request at a time, a
// single-entry holding register towards decode, and redirect handling that
// discards any response belonging to a squashed fetch.
module fetch_unit
    import rv_pkg::*;
#(
    parameter int              XLEN     = rv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
)(
    input  logic      clk,
    input  logic      rst,
    fetch_unit_if.master bus
);

    fetch_state_t    state_q;
    fetch_state_t    state_d;

    logic            redirect;
    logic            capture;
    logic            drop;
    logic            advance;

    logic [XLEN-1:0] pc_q;
    logic            if_valid_q;
    logic [XLEN-1:0] if_instr_q;
    logic [XLEN-1:0] if_pc_q;

    assign redirect = bus.jump | (bus.branch & bus.br_cond);

    pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .load_target (redirect),
        .advance     (advance),
        .target_addr (bus.target_addr),
        .pc_q        (pc_q)
    );

    // Fetch state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus capture/drop/advance strobes; redirect always wins.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        drop    = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = ISSUE;
            end
            ISSUE: begin
                // A redirect here leaves a response in flight that must be eaten.
                state_d = redirect ? DRAIN : WAIT;
            end
            WAIT: begin
                if (redirect) begin
                    // Response arriving with the redirect is stale but closes the request.
                    state_d = bus.imem_rvalid ? ISSUE : DRAIN;
                end else if (bus.imem_rvalid) begin
                    capture = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (redirect) begin
                    drop    = 1'b1;
                    state_d = ISSUE;
                end else if (bus.id_ready) begin
                    drop    = 1'b1;
                    advance = 1'b1;
                    state_d = ISSUE;
                end
            end
            DRAIN: begin
                if (bus.imem_rvalid) begin
                    state_d = ISSUE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Holding register towards decode; stays put until accepted or squashed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid_q <= 1'b0;
            if_instr_q <= XLEN'(NOP_INSTR);
            if_pc_q    <= RESET_PC;
        end else if (capture) begin
            if_valid_q <= 1'b1;
            if_instr_q <= bus.imem_rdata;
            if_pc_q    <= pc_q;
        end else if (drop) begin
            if_valid_q <= 1'b0;
        end
    end

    assign bus.imem_req  = (state_q == ISSUE);
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_instr  = if_instr_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_opcode = if_instr_q[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table for sequential
// fetch, backpressure and branch/jump behaviour, followed by hand-written
// sequences for long-latency drain, same-cycle redirect+response and a
// mid-cycle asynchronous reset. A second instance exercises PC wrap-around.
module tb_fetch_unit;

    logic clk;
    logic rst;

    fetch_unit_if #(.XLEN(32)) bus ();
    fetch_unit_if #(.XLEN(32)) wbus ();

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'hFFFF_FFFC)
    ) u_wrap (
        .clk (clk),
        .rst (rst),
        .bus (wbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instruction memory contents: addr 0 holds addi x1,x0,5; other words
    // carry a varied opcode selected by address bits [4:2].
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [6:0] op;
        case (a[4:2])
            3'd1:    op = 7'b0110111;
            3'd2:    op = 7'b1101111;
            3'd3:    op = 7'b1100011;
            3'd4:    op = 7'b0000011;
            3'd5:    op = 7'b0100011;
            default: op = 7'b0010011;
        endcase
        if (a == 32'h0) return 32'h0050_0093;
        return {a[24:0], op};
    endfunction

    // Memory model: captures a request on the negedge it is seen and
    // answers 'lat' cycles later with a single-cycle rvalid pulse.
    int          lat = 1;
    int          cnt = 0;
    logic [31:0] pend = '0;

    always @(negedge clk) begin
        if (rst) begin
            cnt = 0;
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
        end else begin
            if (cnt == 1) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(pend);
                cnt = 0;
            end else begin
                bus.imem_rvalid = 1'b0;
                if (cnt > 1) cnt = cnt - 1;
            end
            if (bus.imem_req) begin
                pend = bus.imem_addr;
                cnt  = lat;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rdy;
        logic        br;
        logic        jmp;
        logic        cond;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NV = 29;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic rdy, input logic br, input logic jmp,
                                input logic cond, input logic [31:0] tgt,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc);
        vec_t v;
        v.rdy = rdy; v.br = br; v.jmp = jmp; v.cond = cond; v.tgt = tgt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    initial begin
        //            rdy br jmp cnd tgt     req addr   vld pc
        tbl[0]  = mk(1, 0, 0, 0, 32'h0,   0, 32'h000, 0, 32'h000); // IDLE
        tbl[1]  = mk(1, 0, 0, 0, 32'h0,   1, 32'h000, 0, 32'h000); // ISSUE 0
        tbl[2]  = mk(1, 0, 0, 0, 32'h0,   0, 32'h000, 0, 32'h000); // WAIT
        tbl[3]  = mk(0, 0, 0, 0, 32'h0,   0, 32'h000, 1, 32'h000); // FULL, stalled
        tbl[4]  = mk(0, 0, 0, 0, 32'h0,   0, 32'h000, 1, 32'h000);
        tbl[5]  = mk(0, 0, 0, 0, 32'h0,   0, 32'h000, 1, 32'h000);
        tbl[6]  = mk(0, 0, 0, 0, 32'h0,   0, 32'h000, 1, 32'h000);
        tbl[7]  = mk(0, 0, 0, 0, 32'h0,   0, 32'h000, 1, 32'h000);
        tbl[8]  = mk(1, 0, 0, 0, 32'h0,   0, 32'h000, 1, 32'h000); // accept
        tbl[9]  = mk(1, 0, 0, 0, 32'h0,   1, 32'h004, 0, 32'h000); // ISSUE 4
        tbl[10] = mk(1, 0, 0, 0, 32'h0,   0, 32'h004, 0, 32'h000);
        tbl[11] = mk(1, 0, 0, 0, 32'h0,   0, 32'h004, 1, 32'h004);
        tbl[12] = mk(1, 0, 0, 0, 32'h0,   1, 32'h008, 0, 32'h000); // ISSUE 8
        tbl[13] = mk(1, 0, 0, 0, 32'h0,   0, 32'h008, 0, 32'h000);
        tbl[14] = mk(1, 1, 0, 0, 32'h40,  0, 32'h008, 1, 32'h008); // branch not taken
        tbl[15] = mk(1, 0, 0, 0, 32'h0,   1, 32'h00C, 0, 32'h000);
        tbl[16] = mk(1, 0, 0, 0, 32'h0,   0, 32'h00C, 0, 32'h000);
        tbl[17] = mk(1, 1, 0, 1, 32'h40,  0, 32'h00C, 1, 32'h00C); // taken, beats id_ready
        tbl[18] = mk(1, 0, 0, 0, 32'h0,   1, 32'h040, 0, 32'h000);
        tbl[19] = mk(1, 0, 0, 0, 32'h0,   0, 32'h040, 0, 32'h000);
        tbl[20] = mk(0, 0, 1, 0, 32'h83,  0, 32'h040, 1, 32'h040); // jump, unaligned target
        tbl[21] = mk(1, 0, 0, 0, 32'h0,   1, 32'h080, 0, 32'h000);
        tbl[22] = mk(1, 0, 0, 0, 32'h0,   0, 32'h080, 0, 32'h000);
        tbl[23] = mk(1, 0, 0, 0, 32'h0,   0, 32'h080, 1, 32'h080);
        tbl[24] = mk(1, 0, 1, 0, 32'h200, 1, 32'h084, 0, 32'h000); // jump during ISSUE
        tbl[25] = mk(1, 0, 0, 0, 32'h0,   0, 32'h200, 0, 32'h000); // DRAIN eats 0x84
        tbl[26] = mk(1, 0, 0, 0, 32'h0,   1, 32'h200, 0, 32'h000);
        tbl[27] = mk(1, 0, 0, 0, 32'h0,   0, 32'h200, 0, 32'h000);
        tbl[28] = mk(1, 0, 0, 0, 32'h0,   0, 32'h200, 1, 32'h200);

        rst = 1'b1;
        bus.branch = 1'b0; bus.jump = 1'b0; bus.br_cond = 1'b0;
        bus.target_addr = '0; bus.id_ready = 1'b0;
        wbus.branch = 1'b0; wbus.jump = 1'b0; wbus.br_cond = 1'b0;
        wbus.target_addr = '0; wbus.id_ready = 1'b1;
        wbus.imem_rvalid = 1'b1; wbus.imem_rdata = 32'h0000_0013;

        repeat (3) @(negedge clk);
        chk("rst_req",    32'(bus.imem_req),  32'h0);
        chk("rst_addr",   bus.imem_addr,      32'h0);
        chk("rst_valid",  32'(bus.if_valid),  32'h0);
        chk("rst_instr",  bus.if_instr,       32'h0000_0013);
        chk("rst_pc",     bus.if_pc,          32'h0);
        chk("rst_opcode", 32'(bus.if_opcode), 32'h13);
        chk("wrap_rst_addr", wbus.imem_addr,  32'hFFFF_FFFC);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            chk($sformatf("r%0d_req", i),   32'(bus.imem_req), 32'(tbl[i].e_req));
            chk($sformatf("r%0d_addr", i),  bus.imem_addr,     tbl[i].e_addr);
            chk($sformatf("r%0d_valid", i), 32'(bus.if_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk($sformatf("r%0d_pc", i),     bus.if_pc,          tbl[i].e_pc);
                chk($sformatf("r%0d_instr", i),  bus.if_instr,       mem_word(tbl[i].e_pc));
                chk($sformatf("r%0d_opcode", i), 32'(bus.if_opcode), 32'(mem_word(tbl[i].e_pc) & 32'h7F));
            end
            if (i == 1) begin
                chk("wrap_first_req",  32'(wbus.imem_req), 32'h1);
                chk("wrap_first_addr", wbus.imem_addr,     32'hFFFF_FFFC);
            end
            if (i == 3) chk("wrap_if_pc", wbus.if_pc, 32'hFFFF_FFFC);
            if (i == 4) begin
                chk("wrap_next_req",  32'(wbus.imem_req), 32'h1);
                chk("wrap_next_addr", wbus.imem_addr,     32'h0);
            end
            bus.id_ready    = tbl[i].rdy;
            bus.branch      = tbl[i].br;
            bus.jump        = tbl[i].jmp;
            bus.br_cond     = tbl[i].cond;
            bus.target_addr = tbl[i].tgt;
            if (i == NV - 1) lat = 3;
            @(negedge clk);
        end

        // Jump while a latency-3 request is outstanding.
        chk("j3_issue_addr", bus.imem_addr, 32'h204);
        chk("j3_issue_req",  32'(bus.imem_req), 32'h1);
        @(negedge clk);
        chk("j3_wait_req", 32'(bus.imem_req), 32'h0);
        @(negedge clk);
        bus.jump = 1'b1; bus.target_addr = 32'h103;
        @(negedge clk);
        bus.jump = 1'b0; bus.target_addr = 32'h0;
        chk("j3_drain_addr",  bus.imem_addr,      32'h100);
        chk("j3_drain_req",   32'(bus.imem_req),  32'h0);
        chk("j3_drain_valid", 32'(bus.if_valid),  32'h0);
        @(negedge clk);
        chk("j3_reissue_req",   32'(bus.imem_req), 32'h1);
        chk("j3_reissue_addr",  bus.imem_addr,     32'h100);
        chk("j3_stale_dropped", 32'(bus.if_valid), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("j3_wait%0d_valid", k), 32'(bus.if_valid), 32'h0);
        end
        @(negedge clk);
        chk("j3_full_valid", 32'(bus.if_valid), 32'h1);
        chk("j3_full_pc",    bus.if_pc,         32'h100);
        chk("j3_full_instr", bus.if_instr,      mem_word(32'h100));
        lat = 1;

        // Redirect and response in the same WAIT cycle.
        @(negedge clk);
        chk("rw_issue_addr", bus.imem_addr, 32'h104);
        @(negedge clk);
        bus.id_ready = 1'b0;
        bus.jump = 1'b1; bus.target_addr = 32'h300;
        @(negedge clk);
        bus.jump = 1'b0; bus.target_addr = 32'h0;
        chk("rw_req",   32'(bus.imem_req), 32'h1);
        chk("rw_addr",  bus.imem_addr,     32'h300);
        chk("rw_valid", 32'(bus.if_valid), 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rw_full_valid", 32'(bus.if_valid), 32'h1);
        chk("rw_full_pc",    bus.if_pc,         32'h300);

        // Asynchronous reset between edges while FULL.
        #2 rst = 1'b1;
        #1;
        chk("ar_valid",  32'(bus.if_valid),  32'h0);
        chk("ar_addr",   bus.imem_addr,      32'h0);
        chk("ar_req",    32'(bus.imem_req),  32'h0);
        chk("ar_instr",  bus.if_instr,       32'h0000_0013);
        chk("ar_pc",     bus.if_pc,          32'h0);
        chk("ar_opcode", 32'(bus.if_opcode), 32'h13);
        @(negedge clk);
        rst = 1'b0;
        bus.id_ready = 1'b1;
        chk("ar_idle_req", 32'(bus.imem_req), 32'h0);
        @(negedge clk);
        chk("ar_issue_req",  32'(bus.imem_req), 32'h1);
        chk("ar_issue_addr", bus.imem_addr,     32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
